wb_sram_target: RTL

//  Wishbone B4 registered-feedback slave backed by a synchronous word SRAM. It is
//  the responder at an interconnect slave port, e.g. s0/s1 of wb_interconnect_NxN.

---
 rtl/wb_sram_target.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wb_sram_target.sv
// Wishbone B4 registered-feedback slave in front of a synchronous word SRAM.
// Handles classic cycles plus constant-address and incrementing bursts
// (linear and wrap4/8/16). Requests outside the address window get a
// single-cycle ERR. The window is decoded only on the first request; burst
// beats after that always ACK.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for CYC&STB; latch word index, prefetch read data
// ST_ACC   | first beat: ACK, commit write, decide burst vs. done
// ST_BURST | one beat per cycle while STB high; CTI=111 ends the burst
// ST_ERR   | out-of-window request: ERR for one cycle, back to idle
module wb_sram_target #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   s_adr,
    input  logic [WB_DATA_WIDTH-1:0]   s_dat_w,
    input  logic [WB_DATA_WIDTH/8-1:0] s_sel,
    input  logic                       s_cyc,
    input  logic                       s_stb,
    input  logic                       s_we,
    input  logic [2:0]                 s_cti,
    input  logic [1:0]                 s_bte,
    output logic [WB_DATA_WIDTH-1:0]   s_dat_r,
    output logic                       s_ack,
    output logic                       s_err
);

    localparam int SEL_W    = WB_DATA_WIDTH / 8;
    localparam int BYTE_LSB = $clog2(SEL_W);
    localparam int DEPTH    = 2 ** MEM_ADDR_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_BURST, ST_ERR} state_t;

    state_t                     state;
    logic [MEM_ADDR_BITS-1:0]   addr;
    logic                       burst_const;
    logic [1:0]                 burst_bte;
    logic [WB_DATA_WIDTH-1:0]   mem [DEPTH];

    logic [WB_ADDR_WIDTH-1:0]   adr_off;
    logic [WB_ADDR_WIDTH-1:0]   widx_full;
    logic [MEM_ADDR_BITS-1:0]   widx;
    logic [MEM_ADDR_BITS-1:0]   nxt_acc;
    logic [MEM_ADDR_BITS-1:0]   nxt_burst;
    logic                       req;
    logic                       in_win;
    logic                       cti_burst;
    logic                       wr_en;

    // Next burst address: hold for constant bursts, otherwise increment only
    // the bits inside the wrap mask (all bits for linear, which wraps silently
    // at the top of memory).
    function automatic logic [MEM_ADDR_BITS-1:0] next_addr(
        input logic [MEM_ADDR_BITS-1:0] a,
        input logic                     hold,
        input logic [1:0]               bte
    );
        logic [MEM_ADDR_BITS-1:0] mask;
        logic [MEM_ADDR_BITS-1:0] inc;
        inc = a + MEM_ADDR_BITS'(1);
        case (bte)
            2'b01:   mask = MEM_ADDR_BITS'(3);
            2'b10:   mask = MEM_ADDR_BITS'(7);
            2'b11:   mask = MEM_ADDR_BITS'(15);
            default: mask = '1;
        endcase
        if (hold) begin
            return a;
        end
        return (a & ~mask) | (inc & mask);
    endfunction

    assign req       = s_cyc & s_stb;
    assign adr_off   = s_adr - ADDR_BASE;
    assign widx_full = adr_off >> BYTE_LSB;
    assign widx      = widx_full[MEM_ADDR_BITS-1:0];
    assign in_win    = (s_adr >= ADDR_BASE) && ((widx_full >> MEM_ADDR_BITS) == '0);
    assign cti_burst = (s_cti == 3'b001) || (s_cti == 3'b010);
    assign nxt_acc   = next_addr(addr, s_cti == 3'b001, s_bte);
    assign nxt_burst = next_addr(addr, burst_const, burst_bte);

    // Handshake outputs gated by the live bus so nothing answers once CYC drops.
    assign s_ack = req & ((state == ST_ACC) || (state == ST_BURST));
    assign s_err = s_cyc & (state == ST_ERR);
    assign wr_en = rstn & s_ack & s_we;

    // Byte-lane write of the current beat; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (s_sel[i]) begin
                    mem[addr][8*i +: 8] <= s_dat_w[8*i +: 8];
                end
            end
        end
    end

    // Transaction sequencer with read prefetch of the next beat's word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            addr        <= '0;
            s_dat_r     <= '0;
            burst_const <= 1'b0;
            burst_bte   <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr <= widx;
                        if (in_win) begin
                            state   <= ST_ACC;
                            s_dat_r <= mem[widx];
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_ACC: begin
                    s_dat_r <= mem[nxt_acc];
                    if (req && cti_burst) begin
                        state       <= ST_BURST;
                        addr        <= nxt_acc;
                        burst_const <= (s_cti == 3'b001);
                        burst_bte   <= s_bte;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (!s_cyc) begin
                        state <= ST_IDLE;
                    end else if (s_stb) begin
                        addr    <= nxt_burst;
                        s_dat_r <= mem[nxt_burst];
                        if (s_cti == 3'b111) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
